// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the two-master shared bus: default widths, the
// bus-master FSM state encoding and the burst op encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package bus_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned LEN_W_DEF  = 5;

  // Bus-master FSM encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] XFER = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StReq  = REQ,
    StXfer = XFER,
    StDone = DONE
  } state_e;

  // Burst op encoding
  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/bus_master_ctrl.sv
// ---------------------------------------------------------------------------
// bus_master_ctrl
// Bus-master front end: captures a burst command, requests the bus from the
// arbiter, issues one address/data beat per granted cycle and releases the
// bus (m_req low) in the DONE cycle.
//
// Ports:
//   clk, reset            bus clock, synchronous active-high reset
//   start/op/base_addr/len command strobe and fields (sampled in IDLE only)
//   busy, done            status: busy while not IDLE, done pulses once
//   wdata, wdata_pop      write-data FIFO head and its pop strobe
//   rdata, rdata_valid    read data returned one cycle after a read beat
//   m_req, m_grant        request/grant handshake with the arbiter
//   m_wr/m_addr/m_dout    bus beat outputs, m_din bus read data
// ---------------------------------------------------------------------------
module bus_master_ctrl
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              op,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  input  logic [DATA_W-1:0] wdata,
  output logic              wdata_pop,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              m_req,
  input  logic              m_grant,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_dout,
  input  logic [DATA_W-1:0] m_din
);

  state_e             r_state;
  state_e             w_state_d;
  logic               r_op;
  logic [ADDR_W-1:0]  r_base;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_idx;
  logic               r_rd_pend;

  logic               w_beat;
  logic               w_last;
  logic               w_capture;

  // A beat is any granted cycle in XFER; a lost grant simply stalls the burst.
  assign w_beat    = (r_state == StXfer) && m_grant;
  assign w_last    = (r_idx == (r_len - LEN_W'(1)));
  assign w_capture = (r_state == StIdle) && start && (len != '0);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: begin
        if (start) begin
          // Zero-length bursts complete without ever touching the bus.
          w_state_d = (len == '0) ? StDone : StReq;
        end
      end
      StReq: begin
        if (m_grant) begin
          w_state_d = StXfer;
        end
      end
      StXfer: begin
        if (w_beat && w_last) begin
          w_state_d = StDone;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    m_req     = 1'b0;
    m_wr      = 1'b0;
    wdata_pop = 1'b0;
    m_dout    = '0;
    busy      = 1'b1;
    done      = 1'b0;
    case (r_state)
      StIdle: busy = 1'b0;
      StReq:  m_req = 1'b1;
      StXfer: begin
        m_req = 1'b1;
        if (m_grant && (r_op == OP_WR)) begin
          m_wr      = 1'b1;
          wdata_pop = 1'b1;
          m_dout    = wdata;
        end
      end
      // m_req drops here so the arbiter can hand over on the next edge.
      StDone:  done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Address wraps modulo 2^ADDR_W.
  assign m_addr      = r_base + ADDR_W'(r_idx);
  assign rdata       = m_din;
  assign rdata_valid = r_rd_pend;

  // Command capture, beat counter and read-pending flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op      <= OP_RD;
      r_base    <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_rd_pend <= 1'b0;
    end else begin
      r_rd_pend <= w_beat && (r_op == OP_RD);
      if (w_capture) begin
        r_op   <= op;
        r_base <= base_addr;
        r_len  <= len;
        r_idx  <= '0;
      end else if (w_beat) begin
        r_idx <= r_idx + LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bus_master_ctrl.sv
// Scoreboard bench for bus_master_ctrl: stimulus pushes expected bus events
// (write beat, read data, done) tagged with their cycle; a negedge monitor
// pops and compares whenever the DUT shows one.
module tb_bus_master_ctrl;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 5;

  localparam int K_W = 0;
  localparam int K_R = 1;
  localparam int K_D = 2;

  typedef struct {
    int          kind;
    int          cyc;
    logic [7:0]  addr;
    logic [31:0] data;
  } ev_t;

  logic          clk;
  logic          reset;
  logic          start;
  logic          op;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] len;
  logic          busy;
  logic          done;
  logic [DW-1:0] wdata;
  logic          wdata_pop;
  logic [DW-1:0] rdata;
  logic          rdata_valid;
  logic          m_req;
  logic          m_grant;
  logic          m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_dout;
  logic [DW-1:0] m_din;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int unsigned wptr     = 0;
  ev_t         sb[$];

  bus_master_ctrl #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .LEN_W (LW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .base_addr  (base_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .wdata      (wdata),
    .wdata_pop  (wdata_pop),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .m_req      (m_req),
    .m_grant    (m_grant),
    .m_wr       (m_wr),
    .m_addr     (m_addr),
    .m_dout     (m_dout),
    .m_din      (m_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write-data FIFO model: head value advances on every pop.
  always @(posedge clk) if (wdata_pop === 1'b1) wptr <= wptr + 1;
  assign wdata = 32'hA000_0000 + wptr;

  // Slave model: read data = address + 0x100, returned the following cycle.
  initial m_din = '0;
  always @(posedge clk) begin
    if (m_req === 1'b1 && m_grant === 1'b1 && m_wr === 1'b0) begin
      m_din <= 32'h100 + 32'(m_addr);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int k, input int c, input logic [7:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic take(input int k);
    ev_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event @cyc %0d: got kind %0d expected none", cyc, k);
      return;
    end
    e = sb.pop_front();
    chk("ev_kind", 32'(k), 32'(e.kind));
    chk("ev_cycle", 32'(cyc), 32'(e.cyc));
    if (k == K_W) begin
      chk("wr_addr", 32'(m_addr), 32'(e.addr));
      chk("wr_data", m_dout, e.data);
      chk("wr_pop_and_wr", 32'({m_wr, wdata_pop}), 32'h3);
    end else if (k == K_R) begin
      chk("rdata", rdata, e.data);
    end else begin
      chk("done_req_low", 32'(m_req), 32'h0);
      chk("done_busy", 32'(busy), 32'h1);
    end
  endtask

  always @(negedge clk) begin
    if (m_wr === 1'b1 || wdata_pop === 1'b1) take(K_W);
    if (rdata_valid === 1'b1) take(K_R);
    if (done === 1'b1) take(K_D);
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_m_req"}, 32'(m_req), 0);
    chk({tag, "_m_wr"}, 32'(m_wr), 0);
    chk({tag, "_m_addr"}, 32'(m_addr), 0);
    chk({tag, "_m_dout"}, m_dout, 0);
    chk({tag, "_wdata_pop"}, 32'(wdata_pop), 0);
    chk({tag, "_rdata_valid"}, 32'(rdata_valid), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b0 && n < max);
    chk("idle_reached", 32'(busy), 0);
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    int s;
    reset     = 1'b1;
    start     = 1'b0;
    op        = 1'b0;
    base_addr = '0;
    len       = '0;
    m_grant   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    reset = 1'b0;

    // Write burst: base 0x10, len 4, grant held
    @(posedge clk); #1;
    s = cyc;
    start = 1'b1; op = 1'b1; base_addr = 8'h10; len = 5'd4; m_grant = 1'b1;
    for (int k = 0; k < 4; k++) push(K_W, s + 2 + k, 8'(8'h10 + k), 32'(32'hA000_0000 + k));
    push(K_D, s + 6, 8'h0, 32'h0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("req_after_start", 32'(m_req), 1);
    wait_idle(20);

    // Wrap + grant loss: base 0xFE, len 4, grant low two cycles after beat 2
    @(posedge clk); #1;
    s = cyc;
    start = 1'b1; op = 1'b1; base_addr = 8'hFE; len = 5'd4; m_grant = 1'b1;
    push(K_W, s + 2, 8'hFE, 32'hA000_0004);
    push(K_W, s + 3, 8'hFF, 32'hA000_0005);
    push(K_W, s + 6, 8'h00, 32'hA000_0006);
    push(K_W, s + 7, 8'h01, 32'hA000_0007);
    push(K_D, s + 8, 8'h0, 32'h0);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    m_grant = 1'b0;
    #1;
    chk("stall1_req", 32'(m_req), 1);
    chk("stall1_wr_pop", 32'({m_wr, wdata_pop}), 0);
    chk("stall1_addr", 32'(m_addr), 32'h00);
    @(posedge clk); #2;
    chk("stall2_req", 32'(m_req), 1);
    chk("stall2_wr_pop", 32'({m_wr, wdata_pop}), 0);
    @(posedge clk); #1;
    m_grant = 1'b1;
    wait_idle(20);

    // Read burst: base 0x20, len 3; a start pulse mid-burst must be ignored
    @(posedge clk); #1;
    s = cyc;
    start = 1'b1; op = 1'b0; base_addr = 8'h20; len = 5'd3; m_grant = 1'b1;
    push(K_R, s + 3, 8'h0, 32'h120);
    push(K_R, s + 4, 8'h0, 32'h121);
    push(K_R, s + 5, 8'h0, 32'h122);
    push(K_D, s + 5, 8'h0, 32'h0);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; op = 1'b1; base_addr = 8'h80; len = 5'd7;
    @(posedge clk); #1;
    start = 1'b0; op = 1'b0;
    wait_idle(20);

    // Zero-length command: done at cycle 1, no request
    @(posedge clk); #1;
    s = cyc;
    start = 1'b1; op = 1'b1; base_addr = 8'h55; len = 5'd0; m_grant = 1'b0;
    push(K_D, s + 1, 8'h0, 32'h0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("len0_no_req", 32'(m_req), 0);
    wait_idle(5);

    // Reset during the second beat of a len-8 read
    @(posedge clk); #1;
    s = cyc;
    start = 1'b1; op = 1'b0; base_addr = 8'h40; len = 5'd8; m_grant = 1'b1;
    push(K_R, s + 3, 8'h0, 32'h140);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_vals("midrst");
    chk("midrst_sb", sb.size(), 0);

    // Fresh len-2 write after the reset
    @(posedge clk); #1;
    s = cyc;
    start = 1'b1; op = 1'b1; base_addr = 8'h30; len = 5'd2; m_grant = 1'b1;
    push(K_W, s + 2, 8'h30, 32'hA000_0008);
    push(K_W, s + 3, 8'h31, 32'hA000_0009);
    push(K_D, s + 4, 8'h0, 32'h0);
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(20);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
